// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter sharing one single-port RAM data port.
// Grants are combinational; responses are routed back one cycle after the grant.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 22,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [31:0]           m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,

  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [31:0]           m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,

  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,

  output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

  logic                 lastGnt_q, lastGnt_d;
  logic [1:0]           rspOwner_q, rspOwner_d;
  logic                 rspRead_q, rspRead_d;
  logic [CNT_WIDTH-1:0] conflictCnt_q, conflictCnt_d;

  logic m0Gnt, m1Gnt, anyGnt;

  // lastGnt_q == 1 means m1 won last, so m0 takes the next contention.
  always_comb begin
    m0Gnt = 1'b0;
    m1Gnt = 1'b0;
    if (rst_n) begin
      if (m0_req_i && (!m1_req_i || lastGnt_q)) begin
        m0Gnt = 1'b1;
      end else if (m1_req_i) begin
        m1Gnt = 1'b1;
      end
    end
  end

  assign anyGnt   = m0Gnt | m1Gnt;
  assign m0_gnt_o = m0Gnt;
  assign m1_gnt_o = m1Gnt;

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_be_o    = 4'h0;
    ram_wdata_o = 32'h0;
    if (m0Gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = m0_we_i;
      ram_addr_o  = m0_addr_i;
      ram_be_o    = m0_be_i;
      ram_wdata_o = m0_wdata_i;
    end else if (m1Gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = m1_we_i;
      ram_addr_o  = m1_addr_i;
      ram_be_o    = m1_be_i;
      ram_wdata_o = m1_wdata_i;
    end
  end

  always_comb begin
    lastGnt_d     = lastGnt_q;
    rspOwner_d    = {anyGnt, m1Gnt};
    rspRead_d     = anyGnt & ~ram_we_o;
    conflictCnt_d = conflictCnt_q;
    if (anyGnt) begin
      lastGnt_d = m1Gnt;
    end
    if (m0_req_i && m1_req_i && (conflictCnt_q != {CNT_WIDTH{1'b1}})) begin
      conflictCnt_d = conflictCnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lastGnt_q     <= 1'b1;
      rspOwner_q    <= 2'b00;
      rspRead_q     <= 1'b0;
      conflictCnt_q <= '0;
    end else begin
      lastGnt_q     <= lastGnt_d;
      rspOwner_q    <= rspOwner_d;
      rspRead_q     <= rspRead_d;
      conflictCnt_q <= conflictCnt_d;
    end
  end

  // Write responses still raise rvalid but carry zero data.
  assign m0_rvalid_o    = rspOwner_q[1] & ~rspOwner_q[0];
  assign m1_rvalid_o    = rspOwner_q[1] &  rspOwner_q[0];
  assign m0_rdata_o     = (m0_rvalid_o && rspRead_q) ? ram_rdata_i : 32'h0;
  assign m1_rdata_o     = (m1_rvalid_o && rspRead_q) ? ram_rdata_i : 32'h0;
  assign conflict_cnt_o = conflictCnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Cycle-by-cycle vector bench for mem_port_arbiter; a small counter width
// lets the saturation case be reached by real contention.
module tb_mem_port_arbiter;
  localparam int AW = 22;
  localparam int CW = 3;

  logic clk;
  logic rst_n;
  logic m0Req, m0We, m1Req, m1We;
  logic [AW-1:0] m0Addr, m1Addr;
  logic [3:0] m0Be, m1Be;
  logic [31:0] m0Wdata, m1Wdata, ramRdata;
  logic m0Gnt, m1Gnt, m0Rvalid, m1Rvalid;
  logic [31:0] m0Rdata, m1Rdata;
  logic ramEn, ramWe;
  logic [AW-1:0] ramAddr;
  logic [3:0] ramBe;
  logic [31:0] ramWdata;
  logic [CW-1:0] conflictCnt;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0Req), .m0_addr_i(m0Addr), .m0_we_i(m0We), .m0_be_i(m0Be), .m0_wdata_i(m0Wdata),
    .m0_gnt_o(m0Gnt), .m0_rvalid_o(m0Rvalid), .m0_rdata_o(m0Rdata),
    .m1_req_i(m1Req), .m1_addr_i(m1Addr), .m1_we_i(m1We), .m1_be_i(m1Be), .m1_wdata_i(m1Wdata),
    .m1_gnt_o(m1Gnt), .m1_rvalid_o(m1Rvalid), .m1_rdata_o(m1Rdata),
    .ram_en_o(ramEn), .ram_we_o(ramWe), .ram_addr_o(ramAddr), .ram_be_o(ramBe),
    .ram_wdata_o(ramWdata), .ram_rdata_i(ramRdata),
    .conflict_cnt_o(conflictCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic chkRsp;
    logic rstN;
    logic m0Req; logic m0We; logic [AW-1:0] m0Addr; logic [3:0] m0Be; logic [31:0] m0Wdata;
    logic m1Req; logic m1We; logic [AW-1:0] m1Addr; logic [3:0] m1Be; logic [31:0] m1Wdata;
    logic [31:0] ramRdata;
    logic expG0; logic expG1; logic expEn; logic expWe;
    logic [AW-1:0] expAddr; logic [3:0] expBe; logic [31:0] expWdata;
    logic expRv0; logic expRv1; logic [31:0] expRd0; logic [31:0] expRd1;
    logic [CW-1:0] expCnt;
  } vec_t;

  function automatic vec_t mkVec(
    logic chkRsp, logic rstN,
    logic r0, logic w0, logic [AW-1:0] a0, logic [3:0] b0, logic [31:0] d0,
    logic r1, logic w1, logic [AW-1:0] a1, logic [3:0] b1, logic [31:0] d1,
    logic [31:0] rd,
    logic g0, logic g1, logic en, logic we, logic [AW-1:0] ea, logic [3:0] eb, logic [31:0] ed,
    logic rv0, logic rv1, logic [31:0] rd0, logic [31:0] rd1, logic [CW-1:0] cnt);
    vec_t v;
    v.chkRsp = chkRsp; v.rstN = rstN;
    v.m0Req = r0; v.m0We = w0; v.m0Addr = a0; v.m0Be = b0; v.m0Wdata = d0;
    v.m1Req = r1; v.m1We = w1; v.m1Addr = a1; v.m1Be = b1; v.m1Wdata = d1;
    v.ramRdata = rd;
    v.expG0 = g0; v.expG1 = g1; v.expEn = en; v.expWe = we;
    v.expAddr = ea; v.expBe = eb; v.expWdata = ed;
    v.expRv0 = rv0; v.expRv1 = rv1; v.expRd0 = rd0; v.expRd1 = rd1; v.expCnt = cnt;
    return v;
  endfunction

  task automatic checkVal(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Inputs change on the falling edge, well away from the sampling rising edge.
  task automatic applyStimulus(vec_t v);
    @(negedge clk);
    rst_n = v.rstN;
    m0Req = v.m0Req; m0We = v.m0We; m0Addr = v.m0Addr; m0Be = v.m0Be; m0Wdata = v.m0Wdata;
    m1Req = v.m1Req; m1We = v.m1We; m1Addr = v.m1Addr; m1Be = v.m1Be; m1Wdata = v.m1Wdata;
    ramRdata = v.ramRdata;
  endtask

  task automatic checkOutput(vec_t v, int idx);
    #2;
    checkVal("m0_gnt", idx, 32'(m0Gnt), 32'(v.expG0));
    checkVal("m1_gnt", idx, 32'(m1Gnt), 32'(v.expG1));
    checkVal("ram_en", idx, 32'(ramEn), 32'(v.expEn));
    checkVal("ram_we", idx, 32'(ramWe), 32'(v.expWe));
    checkVal("ram_addr", idx, 32'(ramAddr), 32'(v.expAddr));
    checkVal("ram_be", idx, 32'(ramBe), 32'(v.expBe));
    checkVal("ram_wdata", idx, ramWdata, v.expWdata);
    checkVal("conflict_cnt", idx, 32'(conflictCnt), 32'(v.expCnt));
    if (v.chkRsp) begin
      checkVal("m0_rvalid", idx, 32'(m0Rvalid), 32'(v.expRv0));
      checkVal("m1_rvalid", idx, 32'(m1Rvalid), 32'(v.expRv1));
      checkVal("m0_rdata", idx, m0Rdata, v.expRd0);
      checkVal("m1_rdata", idx, m1Rdata, v.expRd1);
    end
  endtask

  vec_t vecs[$];
  vec_t hand[$];

  initial begin
    rst_n = 1'b0;
    m0Req = 1'b0; m0We = 1'b0; m0Addr = '0; m0Be = 4'h0; m0Wdata = 32'h0;
    m1Req = 1'b0; m1We = 1'b0; m1Addr = '0; m1Be = 4'h0; m1Wdata = 32'h0;
    ramRdata = 32'h0;

    // Reset with both requesting: nothing may reach the RAM.
    vecs.push_back(mkVec(1, 0, 1,1,22'h100,4'hF,32'h11111111, 1,1,22'h040,4'h3,32'h22222222, 32'h0,
                         0,0,0,0,22'h0,4'h0,32'h0, 0,0,32'h0,32'h0, 3'd0));
    // Six cycles of contention: m0 wins first, then strict alternation.
    vecs.push_back(mkVec(1, 1, 1,0,22'h200,4'hF,32'h0, 1,0,22'h300,4'hC,32'h12345678, 32'hA0000002,
                         1,0,1,0,22'h200,4'hF,32'h0, 0,0,32'h0,32'h0, 3'd0));
    vecs.push_back(mkVec(1, 1, 1,0,22'h200,4'hF,32'h0, 1,0,22'h300,4'hC,32'h12345678, 32'hA0000003,
                         0,1,1,0,22'h300,4'hC,32'h12345678, 1,0,32'hA0000003,32'h0, 3'd1));
    vecs.push_back(mkVec(1, 1, 1,0,22'h200,4'hF,32'h0, 1,0,22'h300,4'hC,32'h12345678, 32'hA0000004,
                         1,0,1,0,22'h200,4'hF,32'h0, 0,1,32'h0,32'hA0000004, 3'd2));
    vecs.push_back(mkVec(1, 1, 1,0,22'h200,4'hF,32'h0, 1,0,22'h300,4'hC,32'h12345678, 32'hA0000005,
                         0,1,1,0,22'h300,4'hC,32'h12345678, 1,0,32'hA0000005,32'h0, 3'd3));
    vecs.push_back(mkVec(1, 1, 1,0,22'h200,4'hF,32'h0, 1,0,22'h300,4'hC,32'h12345678, 32'hA0000006,
                         1,0,1,0,22'h200,4'hF,32'h0, 0,1,32'h0,32'hA0000006, 3'd4));
    vecs.push_back(mkVec(1, 1, 1,0,22'h200,4'hF,32'h0, 1,0,22'h300,4'hC,32'h12345678, 32'hA0000007,
                         0,1,1,0,22'h300,4'hC,32'h12345678, 1,0,32'hA0000007,32'h0, 3'd5));
    vecs.push_back(mkVec(1, 1, 0,0,22'h0,4'h0,32'h0, 0,0,22'h0,4'h0,32'h0, 32'hA0000008,
                         0,0,0,0,22'h0,4'h0,32'h0, 0,1,32'h0,32'hA0000008, 3'd6));
    // Lone m0 read, then m1 write alongside m0's response.
    vecs.push_back(mkVec(1, 1, 1,0,22'h100,4'hF,32'h0, 0,0,22'h0,4'h0,32'h0, 32'h0,
                         1,0,1,0,22'h100,4'hF,32'h0, 0,0,32'h0,32'h0, 3'd6));
    vecs.push_back(mkVec(1, 1, 0,0,22'h0,4'h0,32'h0, 1,1,22'h040,4'h3,32'hDEADBEEF, 32'h55AA55AA,
                         0,1,1,1,22'h040,4'h3,32'hDEADBEEF, 1,0,32'h55AA55AA,32'h0, 3'd6));
    // Alternating single requests, each response lands one cycle later.
    vecs.push_back(mkVec(1, 1, 1,0,22'h104,4'hF,32'h0, 0,0,22'h0,4'h0,32'h0, 32'h77777777,
                         1,0,1,0,22'h104,4'hF,32'h0, 0,1,32'h0,32'h0, 3'd6));
    vecs.push_back(mkVec(1, 1, 0,0,22'h0,4'h0,32'h0, 1,0,22'h044,4'hF,32'h0, 32'h0BAD0012,
                         0,1,1,0,22'h044,4'hF,32'h0, 1,0,32'h0BAD0012,32'h0, 3'd6));
    vecs.push_back(mkVec(1, 1, 1,1,22'h108,4'hF,32'h0000FFFF, 0,0,22'h0,4'h0,32'h0, 32'h0BAD0013,
                         1,0,1,1,22'h108,4'hF,32'h0000FFFF, 0,1,32'h0,32'h0BAD0013, 3'd6));
    vecs.push_back(mkVec(1, 1, 0,0,22'h0,4'h0,32'h0, 0,0,22'h0,4'h0,32'h0, 32'h0BAD0014,
                         0,0,0,0,22'h0,4'h0,32'h0, 1,0,32'h0,32'h0, 3'd6));

    @(negedge clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Counter sits at 6 of max 7; three more contention cycles must stop at 7.
    hand.push_back(mkVec(1, 1, 1,0,22'h200,4'hF,32'h0, 1,0,22'h300,4'hC,32'h0, 32'h0,
                         0,1,1,0,22'h300,4'hC,32'h0, 0,0,32'h0,32'h0, 3'd6));
    hand.push_back(mkVec(1, 1, 1,0,22'h200,4'hF,32'h0, 1,0,22'h300,4'hC,32'h0, 32'h00000B02,
                         1,0,1,0,22'h200,4'hF,32'h0, 0,1,32'h0,32'h00000B02, 3'd7));
    hand.push_back(mkVec(1, 1, 1,0,22'h200,4'hF,32'h0, 1,0,22'h300,4'hC,32'h0, 32'h00000B03,
                         0,1,1,0,22'h300,4'hC,32'h0, 1,0,32'h00000B03,32'h0, 3'd7));
    hand.push_back(mkVec(1, 1, 0,0,22'h0,4'h0,32'h0, 0,0,22'h0,4'h0,32'h0, 32'h0,
                         0,0,0,0,22'h0,4'h0,32'h0, 0,1,32'h0,32'h0, 3'd7));
    // m1 then m0 granted, reset lands on m0's response cycle.
    hand.push_back(mkVec(1, 1, 0,0,22'h0,4'h0,32'h0, 1,0,22'h048,4'hF,32'h0, 32'h0,
                         0,1,1,0,22'h048,4'hF,32'h0, 0,0,32'h0,32'h0, 3'd7));
    hand.push_back(mkVec(1, 1, 1,0,22'h100,4'hF,32'h0, 0,0,22'h0,4'h0,32'h0, 32'hC0C0C0C0,
                         1,0,1,0,22'h100,4'hF,32'h0, 0,1,32'h0,32'hC0C0C0C0, 3'd7));
    hand.push_back(mkVec(0, 0, 1,0,22'h100,4'hF,32'h0, 1,0,22'h048,4'hF,32'h0, 32'h12121212,
                         0,0,0,0,22'h0,4'h0,32'h0, 0,0,32'h0,32'h0, 3'd7));
    hand.push_back(mkVec(1, 1, 0,0,22'h0,4'h0,32'h0, 0,0,22'h0,4'h0,32'h0, 32'h34343434,
                         0,0,0,0,22'h0,4'h0,32'h0, 0,0,32'h0,32'h0, 3'd0));
    // Round-robin pointer must be back at "m1 last", so m0 wins.
    hand.push_back(mkVec(1, 1, 1,0,22'h100,4'hF,32'h0, 1,0,22'h048,4'hF,32'h0, 32'h0,
                         1,0,1,0,22'h100,4'hF,32'h0, 0,0,32'h0,32'h0, 3'd0));
    hand.push_back(mkVec(1, 1, 0,0,22'h0,4'h0,32'h0, 0,0,22'h0,4'h0,32'h0, 32'h56565656,
                         0,0,0,0,22'h0,4'h0,32'h0, 1,0,32'h56565656,32'h0, 3'd1));

    foreach (hand[i]) begin
      applyStimulus(hand[i]);
      checkOutput(hand[i], 100 + i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
